// File: rtl/round_sequencer_pkg.sv
// Shared phase codes, card destinations and settlement helper for the round sequencer.
package round_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_BET    = 3'd0,
    PH_DEAL_D = 3'd1,
    PH_DEAL_P = 3'd2,
    PH_PLAY1  = 3'd3,
    PH_PLAY2  = 3'd4,
    PH_DEALER = 3'd5,
    PH_RESULT = 3'd6
  } phase_e;

  localparam logic [1:0] DST_H1  = 2'd0;
  localparam logic [1:0] DST_H2  = 2'd1;
  localparam logic [1:0] DST_DLR = 2'd2;

  localparam logic [5:0] BLACKJACK = 6'd21;
  localparam logic [3:0] ACE       = 4'd11;

  // Signed coin change for one hand against the dealer.
  function automatic logic signed [7:0] hand_delta(input logic [5:0] score,
                                                   input logic [5:0] dealer,
                                                   input logic [5:0] bet,
                                                   input logic       bj);
    logic signed [7:0] b;
    b = $signed({2'b00, bet});
    if (score > BLACKJACK)                      return -b;
    if (bj && dealer != BLACKJACK)              return b + $signed({3'b000, bet[5:1]});
    if (dealer > BLACKJACK || score > dealer)   return b;
    if (score == dealer)                        return 8'sd0;
    return -b;
  endfunction

endpackage

// File: rtl/round_sequencer_hand_scorer.sv
// One hand: running sum with soft-ace demotion and a card count.
module hand_scorer
  import round_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [3:0] value,
  output logic [5:0] score,
  output logic [3:0] ncards
);

  logic [5:0] sum_q, sum_d;
  logic [2:0] soft_q, soft_d;
  logic [3:0] n_q, n_base;

  // Add the card onto the (optionally cleared) hand, then demote soft aces while over 21.
  always_comb begin
    sum_d  = clr ? 6'd0 : sum_q;
    soft_d = clr ? 3'd0 : soft_q;
    n_base = clr ? 4'd0 : n_q;
    sum_d  = sum_d + {2'b00, value};
    if (value == ACE) soft_d = soft_d + 3'd1;
    for (int i = 0; i < 2; i++) begin
      if (sum_d > BLACKJACK && soft_d != 3'd0) begin
        sum_d  = sum_d - 6'd10;
        soft_d = soft_d - 3'd1;
      end
    end
  end

  // Hand state; clr together with add restarts the hand with that single card.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= '0;
      soft_q <= '0;
      n_q    <= '0;
    end else if (add) begin
      sum_q  <= sum_d;
      soft_q <= soft_d;
      n_q    <= (n_base == 4'hF) ? n_base : n_base + 4'd1;
    end else if (clr) begin
      sum_q  <= '0;
      soft_q <= '0;
      n_q    <= '0;
    end
  end

  assign score  = sum_q;
  assign ncards = n_q;

endmodule

// File: rtl/round_sequencer.sv
// Blackjack round phase controller: buttons -> card requests, three hand scorers, coin ledger.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter logic [4:0] START_COIN   = 5'd10,
  parameter logic [5:0] DEALER_STAND = 6'd17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  input  logic       hit,
  input  logic       stand,
  input  logic       double,
  input  logic       split,
  input  logic       bet_8,
  input  logic       bet_4,
  input  logic       bet_2,
  input  logic       bet_1,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_value,
  output logic [1:0] card_dst,
  output logic [2:0] phase,
  output logic [5:0] player_score,
  output logic [5:0] split_score,
  output logic [5:0] dealer_score,
  output logic [3:0] new_card,
  output logic [4:0] current_coin,
  output logic       can_split,
  output logic       win,
  output logic       lose,
  output logic       draw
);

  phase_e      ph_q, ph_d;
  logic        req_q, req_d;
  logic [1:0]  dst_q, dst_d;
  logic [5:0]  bet_q, bet_d;
  logic        sp_done_q, sp_done_d, dbl_q, dbl_d;
  logic [1:0]  sp_pend_q, sp_pend_d;   // 1: split card for hand1 due, 2: for hand2
  logic [4:0]  coin_q, coin_d;
  logic        win_q, win_d, lose_q, lose_d, draw_q, draw_d;
  logic [4:0]  btn_q1, btn_q2, pulse;
  logic        p_split, p_dbl, p_hit, p_stand, p_next;
  logic [3:0]  h1_c1, new_card_q;
  logic        h1_pair;

  logic [2:0]       clr, add;
  logic [2:0][3:0]  val;
  logic [2:0][5:0]  sc;
  logic [2:0][3:0]  nc;

  logic              acc, close1, close2, bust1, bust2, bj1, bj2, bet2_ok;
  logic [3:0]        bet_in;
  logic signed [7:0] d1, d2, net;
  logic signed [8:0] csum;

  for (genvar g = 0; g < 3; g++) begin : g_hand
    hand_scorer u_hand (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr[g]),
      .add    (add[g]),
      .value  (val[g]),
      .score  (sc[g]),
      .ncards (nc[g])
    );
  end

  // Button edge detect; one pulse per press, only one action per cycle by priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q1 <= '0;
      btn_q2 <= '0;
    end else begin
      btn_q1 <= {split, double, hit, stand, next};
      btn_q2 <= btn_q1;
    end
  end

  assign pulse   = btn_q1 & ~btn_q2;
  assign p_split = !req_q && pulse[4];
  assign p_dbl   = !req_q && pulse[3] && !pulse[4];
  assign p_hit   = !req_q && pulse[2] && !(|pulse[4:3]);
  assign p_stand = !req_q && pulse[1] && !(|pulse[4:2]);
  assign p_next  = !req_q && pulse[0] && !(|pulse[4:1]);

  assign bet_in  = {bet_8, bet_4, bet_2, bet_1};
  assign acc     = card_ack && req_q;
  assign bust1   = sc[0] > BLACKJACK;
  assign bust2   = sc[1] > BLACKJACK;
  assign bj1     = nc[0] == 4'd2 && sc[0] == BLACKJACK;
  assign bj2     = nc[1] == 4'd2 && sc[1] == BLACKJACK;
  assign bet2_ok = {bet_q, 1'b0} <= {2'b00, coin_q};
  assign can_split = ph_q == PH_PLAY1 && nc[0] == 4'd2 && h1_pair && !sp_done_q && bet2_ok;

  // Settlement of the current hands; only used on the RESULT entry cycle.
  assign d1   = hand_delta(sc[0], sc[2], bet_q, bj1 && !sp_done_q);
  assign d2   = sp_done_q ? hand_delta(sc[1], sc[2], bet_q, 1'b0) : 8'sd0;
  assign net  = d1 + d2;
  assign csum = $signed({4'b0000, coin_q}) + $signed({net[7], net});

  // Phase sequencing, card requests, scorer strobes and coin ledger next-state.
  always_comb begin
    ph_d = ph_q;  req_d = req_q;  dst_d = dst_q;  bet_d = bet_q;
    sp_done_d = sp_done_q;  dbl_d = dbl_q;  sp_pend_d = sp_pend_q;
    coin_d = coin_q;  win_d = win_q;  lose_d = lose_q;  draw_d = draw_q;
    close1 = 1'b0;  close2 = 1'b0;
    clr = '0;
    add[0] = acc && dst_q == DST_H1;
    add[1] = acc && dst_q == DST_H2;
    add[2] = acc && dst_q == DST_DLR;
    val = {3{card_value}};

    if (acc) begin
      req_d = 1'b0;
      if (sp_pend_q == 2'd1)      sp_pend_d = 2'd2;
      else if (sp_pend_q == 2'd2) sp_pend_d = 2'd0;
    end

    case (ph_q)
      PH_BET: begin
        if (p_next && bet_in != 4'd0 && {1'b0, bet_in} <= coin_q) begin
          bet_d = {2'b00, bet_in};
          ph_d  = PH_DEAL_D;
        end
      end
      PH_DEAL_D: begin
        if (!req_q) begin
          if (nc[2] < 4'd2) begin req_d = 1'b1; dst_d = DST_DLR; end
          else ph_d = PH_DEAL_P;
        end
      end
      PH_DEAL_P: begin
        if (!req_q) begin
          if (nc[0] < 4'd2) begin req_d = 1'b1; dst_d = DST_H1; end
          else ph_d = PH_PLAY1;
        end
      end
      PH_PLAY1: begin
        if (!req_q) begin
          if (sp_pend_q != 2'd0) begin
            req_d = 1'b1;
            dst_d = (sp_pend_q == 2'd1) ? DST_H1 : DST_H2;
          end else if (dbl_q || bj1) begin
            close1 = 1'b1;
          end else if (p_split) begin
            if (can_split) begin
              // both hands restart from the paired card, then draw hand1 first
              clr[1:0] = 2'b11;  add[1:0] = 2'b11;
              val[0] = h1_c1;  val[1] = h1_c1;
              sp_done_d = 1'b1;  sp_pend_d = 2'd1;
              req_d = 1'b1;  dst_d = DST_H1;
            end
          end else if (p_dbl) begin
            if (nc[0] == 4'd2 && bet2_ok && !bust1) begin
              bet_d = {bet_q[4:0], 1'b0};
              dbl_d = 1'b1;  req_d = 1'b1;  dst_d = DST_H1;
            end
          end else if (p_hit) begin
            if (!bust1) begin req_d = 1'b1; dst_d = DST_H1; end
          end else if (p_stand || p_next) begin
            close1 = 1'b1;
          end
        end
      end
      PH_PLAY2: begin
        if (!req_q) begin
          if (bj2) close2 = 1'b1;
          else if (p_hit) begin
            if (!bust2) begin req_d = 1'b1; dst_d = DST_H2; end
          end else if (p_stand || p_next) close2 = 1'b1;
        end
      end
      PH_DEALER: begin
        if (!req_q) begin
          if (sc[2] < DEALER_STAND) begin req_d = 1'b1; dst_d = DST_DLR; end
          else if (p_next) ph_d = PH_RESULT;
        end
      end
      PH_RESULT: begin
        if (p_next) begin
          ph_d = PH_BET;
          clr = 3'b111;
          bet_d = '0;  sp_done_d = 1'b0;  dbl_d = 1'b0;
          win_d = 1'b0;  lose_d = 1'b0;  draw_d = 1'b0;
        end
      end
      default: ph_d = PH_BET;
    endcase

    if (close1) ph_d = sp_done_q ? PH_PLAY2 : (bust1 ? PH_RESULT : PH_DEALER);
    if (close2) ph_d = (bust1 && bust2) ? PH_RESULT : PH_DEALER;

    if (ph_d == PH_RESULT && ph_q != PH_RESULT) begin
      if (csum < 9'sd0)       coin_d = 5'd0;
      else if (csum > 9'sd31) coin_d = 5'd31;
      else                    coin_d = csum[4:0];
      win_d  = net > 8'sd0;
      lose_d = net < 8'sd0;
      draw_d = net == 8'sd0;
    end
  end

  // Round state register; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q <= PH_BET;  req_q <= 1'b0;  dst_q <= DST_H1;  bet_q <= '0;
      sp_done_q <= 1'b0;  dbl_q <= 1'b0;  sp_pend_q <= '0;
      coin_q <= START_COIN;
      win_q <= 1'b0;  lose_q <= 1'b0;  draw_q <= 1'b0;
    end else begin
      ph_q <= ph_d;  req_q <= req_d;  dst_q <= dst_d;  bet_q <= bet_d;
      sp_done_q <= sp_done_d;  dbl_q <= dbl_d;  sp_pend_q <= sp_pend_d;
      coin_q <= coin_d;
      win_q <= win_d;  lose_q <= lose_d;  draw_q <= draw_d;
    end
  end

  // Last accepted card and hand1 pair tracking for the split check.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_card_q <= '0;  h1_c1 <= '0;  h1_pair <= 1'b0;
    end else begin
      if (acc) new_card_q <= card_value;
      if (add[0]) begin
        if (clr[0] || nc[0] == 4'd0) h1_c1 <= val[0];
        h1_pair <= !clr[0] && nc[0] == 4'd1 && val[0] == h1_c1;
      end else if (clr[0]) begin
        h1_pair <= 1'b0;
      end
    end
  end

  assign card_req     = req_q;
  assign card_dst     = dst_q;
  assign phase        = ph_q;
  assign player_score = sc[0];
  assign split_score  = sc[1];
  assign dealer_score = sc[2];
  assign new_card     = new_card_q;
  assign current_coin = coin_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign draw         = draw_q;

endmodule
